// File: rtl/sdram_bist.sv
`default_nettype none
// ============================================================================
// Module   : sdram_bist
// Purpose  : LFSR write / read-back self-test master for the sdram_burst inport.
//            Optional watchdog abort is built when SDRAM_BIST_TIMEOUT_EN is defined.
// Revision : 1.0
// ============================================================================
module sdram_bist #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                NUM_WORDS      = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter logic [31:0]       SEED           = 32'hACE1_1234,
  parameter int                TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [15:0]       err_count_o,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic              timeout_o,
  output logic [3:0]        inport_wr_o,
  output logic              inport_rd_o,
  output logic [7:0]        inport_len_o,
  output logic [ADDR_W-1:0] inport_addr_o,
  output logic [DATA_W-1:0] inport_write_data_o,
  input  logic              inport_accept_i,
  input  logic              inport_ack_i,
  input  logic              inport_error_i,
  input  logic [DATA_W-1:0] inport_read_data_i
);

  localparam int          IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [31:0] POLY     = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [31:0]         lfsr_q, lfsr_d, lfsr_nxt;
  logic                busy_q, busy_d, done_q, done_d;
  logic [15:0]         err_q, err_d;
  logic [ADDR_W-1:0]   first_q, first_d, addr_q, addr_d;
  logic [3:0]          wr_q, wr_d;
  logic                rd_q, rd_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_inc;
  logic                last_word;
`ifdef SDRAM_BIST_TIMEOUT_EN
  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]         wdog_q, wdog_d;
  logic                timeout_q, timeout_d;
`endif

  // Galois form, shift right, taps folded in after the shift
  assign lfsr_nxt  = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);
  assign last_word = (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;  idx_d  = idx_q;   lfsr_d  = lfsr_q;
    busy_d  = busy_q;   done_d = done_q;  err_d   = err_q;
    first_d = first_q;  addr_d = addr_q;  wr_d    = wr_q;
    rd_d    = rd_q;     wdata_d = wdata_q; err_inc = 1'b0;
`ifdef SDRAM_BIST_TIMEOUT_EN
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_WR_REQ;  busy_d  = 1'b1;  done_d = 1'b0;
          err_d   = '0;        first_d = '0;    idx_d  = '0;
          lfsr_d  = SEED;      wr_d    = 4'hF;  rd_d   = 1'b0;
          addr_d  = BASE_ADDR; wdata_d = SEED;
`ifdef SDRAM_BIST_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      S_WR_REQ: begin
        if (inport_accept_i) begin
          wr_d    = 4'h0;
          state_d = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        if (inport_ack_i) begin
          err_inc = inport_error_i;
          if (last_word) begin
            idx_d   = '0;        lfsr_d = SEED;  state_d = S_RD_REQ;
            rd_d    = 1'b1;      addr_d = BASE_ADDR;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            lfsr_d  = lfsr_nxt;  state_d = S_WR_REQ;  wr_d = 4'hF;
            addr_d  = addr_q + ADDR_W'(4);
            wdata_d = lfsr_nxt;
          end
        end
      end
      S_RD_REQ: begin
        if (inport_accept_i) begin
          rd_d    = 1'b0;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (inport_ack_i) begin
          err_inc = inport_error_i | (inport_read_data_i != lfsr_q);
          lfsr_d  = lfsr_nxt;
          if (last_word) begin
            state_d = S_DONE;  busy_d = 1'b0;  done_d = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_RD_REQ;  rd_d = 1'b1;
            addr_d  = addr_q + ADDR_W'(4);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // addr_q still holds the address of the outstanding word during WAIT
    if (err_inc) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (err_q == 16'd0)    first_d = addr_q;
    end

`ifdef SDRAM_BIST_TIMEOUT_EN
    if (state_q inside {S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT}) begin
      if (wdog_q == WDOG_LIMIT) begin
        timeout_d = 1'b1;  state_d = S_DONE;  busy_d = 1'b0;  done_d = 1'b1;
        wr_d      = 4'h0;  rd_d    = 1'b0;    wdog_d = '0;
      end else if (state_d != state_q) begin
        wdog_d = '0;
      end else begin
        wdog_d = wdog_q + 16'd1;
      end
    end else begin
      wdog_d = '0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;  idx_q  <= '0;    lfsr_q  <= SEED;
      busy_q  <= 1'b0;    done_q <= 1'b0;  err_q   <= '0;
      first_q <= '0;      addr_q <= '0;    wr_q    <= 4'h0;
      rd_q    <= 1'b0;    wdata_q <= '0;
`ifdef SDRAM_BIST_TIMEOUT_EN
      wdog_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;  idx_q  <= idx_d;   lfsr_q  <= lfsr_d;
      busy_q  <= busy_d;   done_q <= done_d;  err_q   <= err_d;
      first_q <= first_d;  addr_q <= addr_d;  wr_q    <= wr_d;
      rd_q    <= rd_d;     wdata_q <= wdata_d;
`ifdef SDRAM_BIST_TIMEOUT_EN
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
`endif
    end
  end

`ifdef SDRAM_BIST_TIMEOUT_EN
  assign timeout_o = timeout_q;
`else
  // Without the watchdog the flag is constant low; the limit is irrelevant
  assign timeout_o = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign pass_o              = done_q && (err_q == 16'd0) && !timeout_o;
  assign err_count_o         = err_q;
  assign first_err_addr_o    = first_q;
  assign inport_wr_o         = wr_q;
  assign inport_rd_o         = rd_q;
  assign inport_len_o        = 8'h00;
  assign inport_addr_o       = addr_q;
  assign inport_write_data_o = wdata_q;

endmodule
`default_nettype wire
